// File: rtl/bt_pkg.sv
// Shared types and constants for the HC-05 UART word receive path.
// BT_RX_PARITY_EN adds the PARITY state to the receiver state enum.
package bt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef BT_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_t;

  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_CR = 8'h0D;

  // 100 MHz system clock at 38400 baud
  localparam int BAUD_DIV_DEFAULT = 2604;

  typedef struct packed {
    logic        line_end;
    logic [15:0] word;
  } fifo_entry_t;

  function automatic logic has_lf(input logic [15:0] w);
    return (w[15:8] == CHAR_LF) || (w[7:0] == CHAR_LF);
  endfunction

endpackage

// File: rtl/bt_uart_rx_word_if.sv
// Word stream from the receiver to the host-side consumer.
// Valid/ready handshake; a pop happens when both are high.
interface bt_uart_rx_word_if;
  logic [15:0] word_out;
  logic        word_line_end;
  logic        word_valid;
  logic        word_ready;

  modport master (
    output word_out,
    output word_line_end,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_out,
    input  word_line_end,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/bt_word_fifo.sv
// Generic first-word-fall-through FIFO; DEPTH must be a power of two.
// Head data reads as zero while empty.
module bt_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             not_empty,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  // a pop frees the slot in the same cycle, so a push into a full FIFO still lands
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && !do_push;

  assign not_empty = !empty;
  assign pop_data  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bt_uart_rx_word.sv
// HC-05 response receiver: 8N1 bytes packed in pairs into 16-bit words and queued.
// Define BT_RX_PARITY_EN for 8E1 frames with a parity_err pulse output.
module bt_uart_rx_word
  import bt_pkg::*;
#(
  parameter int CLKS_PER_BIT = BAUD_DIV_DEFAULT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fpga_rxd,
  input  logic              err_clear,
  bt_uart_rx_word_if.master word_if,
  output logic              framing_err,
  output logic              framing_seen,
  output logic              overrun,
  output logic              rx_busy
`ifdef BT_RX_PARITY_EN
  ,
  output logic              parity_err
`endif
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT);

  logic        rxd_meta;
  logic        rxd_s;
  rx_state_t   state;
  logic [CW-1:0] cnt;
  logic        tick_done;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        hw_full;
  logic [7:0]  hw_byte;
  logic        push;
  fifo_entry_t push_entry;
  fifo_entry_t head;
  logic        head_valid;
  logic        fifo_ovf;
`ifdef BT_RX_PARITY_EN
  logic        par_bad;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= fpga_rxd;
      rxd_s    <= rxd_meta;
    end
  end

  // counter expires after exactly the loaded number of cycles
  assign tick_done = (cnt == CW'(1));
  assign rx_busy   = (state != ST_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      byte_valid   <= 1'b0;
      byte_data    <= '0;
      framing_err  <= 1'b0;
      framing_seen <= 1'b0;
`ifdef BT_RX_PARITY_EN
      parity_err   <= 1'b0;
      par_bad      <= 1'b0;
`endif
    end else begin
      framing_err <= 1'b0;
      byte_valid  <= 1'b0;
`ifdef BT_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
      if (state != ST_IDLE && state != ST_WAIT_IDLE) cnt <= cnt - CW'(1);
      if (err_clear) framing_seen <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!rxd_s) begin
            cnt   <= HALF_BIT;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (tick_done) begin
            if (!rxd_s) begin
              state   <= ST_DATA;
              bit_idx <= '0;
              cnt     <= FULL_BIT;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (tick_done) begin
            shreg <= {rxd_s, shreg[7:1]};
            cnt   <= FULL_BIT;
            if (bit_idx == 3'd7) begin
`ifdef BT_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
`ifdef BT_RX_PARITY_EN
        ST_PARITY: begin
          if (tick_done) begin
            cnt   <= FULL_BIT;
            state <= ST_STOP;
            if (rxd_s != ^shreg) begin
              par_bad    <= 1'b1;
              parity_err <= 1'b1;
            end else begin
              par_bad <= 1'b0;
            end
          end
        end
`endif
        ST_STOP: begin
          if (tick_done) begin
            if (rxd_s) begin
              state     <= ST_IDLE;
              byte_data <= shreg;
`ifdef BT_RX_PARITY_EN
              byte_valid <= !par_bad;
`else
              byte_valid <= 1'b1;
`endif
            end else begin
              framing_err  <= 1'b1;
              framing_seen <= 1'b1;
              state        <= ST_WAIT_IDLE;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (rxd_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A leading LF is flushed on its own so line ends reach the host without waiting for a partner byte.
  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    if (byte_valid) begin
      if (hw_full) begin
        push                = 1'b1;
        push_entry.word     = {hw_byte, byte_data};
        push_entry.line_end = has_lf({hw_byte, byte_data});
      end else if (byte_data == CHAR_LF) begin
        push                = 1'b1;
        push_entry.word     = {CHAR_LF, 8'h00};
        push_entry.line_end = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hw_full <= 1'b0;
      hw_byte <= '0;
    end else if (byte_valid) begin
      if (hw_full) begin
        hw_full <= 1'b0;
      end else if (byte_data != CHAR_LF) begin
        hw_full <= 1'b1;
        hw_byte <= byte_data;
      end
    end
  end

  bt_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (word_if.word_ready),
    .pop_data  (head),
    .not_empty (head_valid),
    .overflow  (fifo_ovf)
  );

  assign word_if.word_out      = head.word;
  assign word_if.word_line_end = head.line_end;
  assign word_if.word_valid    = head_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)         overrun <= 1'b0;
    else if (fifo_ovf) overrun <= 1'b1;
    else if (err_clear) overrun <= 1'b0;
  end

endmodule
